// File: rtl/dice_pkg.sv
// dice_pkg: shared dice face patterns, FSM state encoding and face decode helper
package dice_pkg;
  localparam int PAT_W = 7;
  localparam logic [PAT_W-1:0] FACE_BLANK = 7'b0000000;
  localparam logic [PAT_W-1:0] FACE_1 = 7'b0000001;
  localparam logic [PAT_W-1:0] FACE_2 = 7'b1000010;
  localparam logic [PAT_W-1:0] FACE_3 = 7'b1000011;
  localparam logic [PAT_W-1:0] FACE_4 = 7'b1100110;
  localparam logic [PAT_W-1:0] FACE_5 = 7'b1100111;
  localparam logic [PAT_W-1:0] FACE_6 = 7'b1111110;
  typedef enum logic [1:0] {SETTLE, COUNT, HOLD} state_t;
  function automatic logic [2:0] decode_face(input logic [PAT_W-1:0] p);
    return p == FACE_1 ? 3'd1 : p == FACE_2 ? 3'd2 : p == FACE_3 ? 3'd3 :
           p == FACE_4 ? 3'd4 : p == FACE_5 ? 3'd5 : p == FACE_6 ? 3'd6 : 3'd0;
  endfunction
endpackage

// File: rtl/dice_sync.sv
// dice_sync: W-bit two-flop synchroniser, async active-high reset; ports i_Clk, i_Reset, d (async in), q (synced out)
module dice_sync #(
  parameter int W = 7
) (
  input  logic         i_Clk,
  input  logic         i_Reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  always_ff @(posedge i_Clk or posedge i_Reset)
    if (i_Reset) {q, m} <= '0;
    else {q, m} <= {m, d};
endmodule

// File: rtl/dice_pattern_decoder.sv
// dice_pattern_decoder: debounced dice pattern to face decoder; i_Clk, i_Reset (async), i_Dice in; o_Number, o_Valid (strobe), o_Error, o_Blank out
module dice_pattern_decoder
  import dice_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic [PAT_W-1:0] i_Dice,
  output logic [2:0]       o_Number,
  output logic             o_Valid,
  output logic             o_Error,
  output logic             o_Blank
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  logic [PAT_W-1:0] s, l, a;
  logic [CW-1:0] cnt;
  logic [2:0] face;
  logic diff, done, accept, fresh;
  state_t state, state_nx;
  dice_sync #(.W(PAT_W)) u_sync (.i_Clk(i_Clk), .i_Reset(i_Reset), .d(i_Dice), .q(s));
  assign diff = s != l;
  assign done = cnt == CW'(STABLE_CYCLES - 1);
  always_ff @(posedge i_Clk or posedge i_Reset)
    if (i_Reset) begin
      state <= SETTLE;
      l <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      l <= s;
      cnt <= diff ? '0 : (state != HOLD && !done) ? cnt + 1'b1 : cnt;
    end
  always_comb state_nx = diff ? SETTLE : (state == HOLD || done) ? HOLD : COUNT;
  // a re-accepted copy of the last accepted pattern (bounce) leaves outputs alone
  always_comb begin
    accept = !diff && state != HOLD && done;
    fresh = accept && s != a;
    face = decode_face(s);
  end
  always_ff @(posedge i_Clk or posedge i_Reset)
    if (i_Reset) begin
      a <= FACE_BLANK;
      o_Number <= '0;
      o_Valid <= 1'b0;
      o_Error <= 1'b0;
      o_Blank <= 1'b1;
    end else begin
      o_Valid <= fresh && face != 3'd0;
      if (fresh) begin
        a <= s;
        o_Number <= face;
        o_Error <= face == 3'd0 && s != FACE_BLANK;
        o_Blank <= s == FACE_BLANK;
      end
    end
endmodule

// File: doc/dice_pattern_decoder.md
# dice_pattern_decoder

Converts a 7-bit dice LED pattern back into a face number 1–6, the inverse of the number-to-dice display mapping. It sits on the input side of the dice board, reading seven asynchronous pattern lines from an external die or a looped-back display. The block synchronises and debounces the lines, then accepts only patterns that stay stable. It reports the decoded face with a one-cycle strobe and flags patterns that are not legal faces.

## Interface
- STABLE_CYCLES, 4, consecutive identical synchronised samples required before a pattern is accepted; legal range 1–255
- i_Clk  input  1  system clock; all state updates on its rising edge
- i_Reset  input  1  asynchronous, active-high reset; one clock domain only
- i_Dice  input  7  raw pattern lines, asynchronous to i_Clk; bit 6 is MSB
- o_Number  output  3  last accepted face: 1–6, or 0 for blank/invalid
- o_Valid  output  1  one-cycle pulse when a new legal face is accepted
- o_Error  output  1  level; high while the last accepted pattern is illegal
- o_Blank  output  1  level; high while the last accepted pattern is 7'b0000000

## Operation
- Legal patterns:
  - 7'b0000001 decodes to 1
  - 7'b1000010 decodes to 2
  - 7'b1000011 decodes to 3
  - 7'b1100110 decodes to 4
  - 7'b1100111 decodes to 5
  - 7'b1111110 decodes to 6
  - 7'b0000000 is blank
  - Every other value is illegal.
- Two-flop synchroniser on all 7 bits produces the sample S; a register L holds the previous S.
- State machine with three states:
  - SETTLE: entered after reset, and whenever S ≠ L. The stability counter is cleared.
  - COUNT: S == L; the counter increments each cycle. When the counter reaches STABLE_CYCLES−1, S is accepted and the FSM moves to HOLD.
  - HOLD: S == L and the pattern is already accepted; nothing happens. Any S ≠ L returns to SETTLE.
- Acceptance rule: if the accepted pattern equals the previously accepted pattern (A), outputs are unchanged and no o_Valid pulse is issued. A re-stabilising bounce therefore never re-strobes.
- When a pattern differs from A, it is written to A and the outputs are updated:
  - Legal face: o_Number = face, o_Valid = 1 for one cycle, o_Error = 0, o_Blank = 0.
  - Blank: o_Number = 0, o_Blank = 1, o_Error = 0, no strobe.
  - Illegal: o_Number = 0, o_Error = 1, o_Blank = 0, no strobe.
- The counter saturates and never wraps; its width is the minimum needed to hold STABLE_CYCLES.

## Timing
- Reset values:
  - o_Number = 0, o_Valid = 0, o_Error = 0, o_Blank = 1
  - A = 7'b0000000, synchroniser flops 0, L = 0, counter 0, state SETTLE
- Latency: with i_Dice changing before clock edge k and held, o_Valid is high in the cycle after edge k+2+STABLE_CYCLES, i.e. STABLE_CYCLES+3 edges.
- Any change in S during SETTLE or COUNT restarts the count in the next cycle; only an uninterrupted run of STABLE_CYCLES equal samples is accepted.
- o_Valid is always exactly one cycle wide. Two distinct faces back-to-back produce two pulses at least STABLE_CYCLES+1 cycles apart.
- Reset asserted mid-count or mid-pulse returns all outputs to their reset values immediately, without waiting for a clock edge. After release, the block restarts from SETTLE, so the pattern currently on i_Dice is re-accepted and re-strobed if it is a legal face.
- With STABLE_CYCLES = 1, acceptance occurs on the first cycle where S == L.

## Structure
- Shared package `dice_pkg` holds:
  - the face pattern constants FACE_1..FACE_6 and FACE_BLANK
  - the FSM state encoding
  - the pattern width, 7
- The display encoder imports the same constants, so the encoder and decoder cannot drift apart.
- One sub-module, `dice_sync`: a parameterised-width two-flop synchroniser with asynchronous reset. Decode, counter and FSM stay in the top level.

## Test plan
- Reset release, then i_Dice = 7'b1100110 held with STABLE_CYCLES = 4 → o_Valid pulses once, 7 edges after the first sampling edge; o_Number = 4; o_Blank falls.
- 7'b0000001 with 1-cycle glitches to 7'b0000011 every 3 cycles for 20 cycles, then steady → no pulse during the glitching; one pulse with o_Number = 1 once steady.
- 7'b1111110 accepted, then a 2-cycle glitch, then 7'b1111110 again → exactly one o_Valid in total; o_Number stays 6.
- i_Dice = 7'b0101010 held → o_Error = 1, o_Number = 0, no o_Valid; then 7'b1000011 held → o_Error = 0, o_Number = 3, one pulse.
- i_Reset asserted mid-count with 7'b1100111 held, then released → outputs at reset values during reset; one pulse with o_Number = 5 after STABLE_CYCLES+3 edges from release.
- Sweep all 128 patterns, each held for 10 cycles → 6 strobes with the correct faces, 1 blank, and 121 error assertions.
